// File: rtl/blink_pkg.sv
// blink_pkg: shared FSM states, legal widths and cipher tables for the blink round engine
package blink_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;
  localparam int BL_SMALL = 64;
  localparam int BL_LARGE = 128;
  localparam int IDXW_DEF = 6;
  localparam logic [3:0] SBOX [16] = '{4'hc, 4'h6, 4'h9, 4'h0, 4'h1, 4'ha, 4'h2, 4'hb,
                                       4'h3, 4'h8, 4'h5, 4'hd, 4'h4, 4'he, 4'h7, 4'hf};
  localparam int SHUF [16] = '{0, 1, 2, 3, 7, 4, 5, 6, 10, 11, 8, 9, 13, 14, 15, 12};
endpackage

// File: rtl/blink_round.sv
// blink_round: one cipher round -- SubCells, MixColumns with AddKey, ShuffleCells
module blink_round
  import blink_pkg::*;
#(
  parameter int BLOCK_LEN = 64
) (
  input  logic [BLOCK_LEN-1:0] s,
  input  logic [BLOCK_LEN-1:0] k,
  output logic [BLOCK_LEN-1:0] y
);
  localparam int CW = BLOCK_LEN / 16;
  logic [CW-1:0] a [16];
  logic [CW-1:0] m [16];
  // substitute every nibble of every cell, then add the round tweakey
  always_comb begin
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < CW / 4; j++)
        a[i][j*4 +: 4] = SBOX[s[i*CW + j*4 +: 4]] ^ k[i*CW + j*4 +: 4];
  end
  for (genvar c = 0; c < 4; c++) begin : g_col
    assign m[c]      = a[c] ^ a[8+c] ^ a[12+c];
    assign m[4+c]    = a[c];
    assign m[8+c]    = a[4+c] ^ a[8+c];
    assign m[12+c]   = a[c] ^ a[8+c];
  end
  for (genvar i = 0; i < 16; i++) begin : g_shuf
    assign y[i*CW +: CW] = m[SHUF[i]];
  end
endmodule

// File: rtl/blink_round_iter.sv
// blink_round_iter: iterative block cipher engine, one round per accepted round key
module blink_round_iter
  import blink_pkg::*;
#(
  parameter int BLOCK_LEN = 64,
  parameter int NR        = 16,
  parameter int IDXW      = IDXW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BLOCK_LEN-1:0] in_data,
  output logic                 rk_req,
  output logic [IDXW-1:0]      rk_idx,
  input  logic                 rk_valid,
  input  logic [BLOCK_LEN-1:0] rk_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BLOCK_LEN-1:0] out_data,
  input  logic                 abort,
  output logic                 busy
);
  fsm_t fsm, fsm_nx;
  logic [BLOCK_LEN-1:0] st, st_nx, rnd;
  logic [IDXW-1:0] cnt, cnt_nx;
  logic last;
  blink_round #(.BLOCK_LEN(BLOCK_LEN)) u_round (.s(st), .k(rk_data), .y(rnd));
  assign last = cnt == IDXW'(NR - 1);
  // state register, round counter and FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= IDLE;
      st  <= '0;
      cnt <= '0;
    end else begin
      fsm <= fsm_nx;
      st  <= st_nx;
      cnt <= cnt_nx;
    end
  end
  // next state: load, iterate on key arrival, hand off; abort overrides everything
  always_comb begin
    fsm_nx = fsm;
    st_nx  = st;
    cnt_nx = cnt;
    case (fsm)
      IDLE: if (in_valid && !abort) begin
        st_nx  = in_data;
        cnt_nx = '0;
        fsm_nx = ROUND;
      end
      ROUND: if (rk_valid) begin
        st_nx  = rnd;
        cnt_nx = last ? cnt : cnt + 1'b1;
        fsm_nx = last ? DONE : ROUND;
      end
      DONE: fsm_nx = out_ready ? IDLE : DONE;
      default: fsm_nx = IDLE;
    endcase
    if (abort) fsm_nx = IDLE;
  end
  assign in_ready  = fsm == IDLE;
  assign rk_req    = fsm == ROUND;
  assign rk_idx    = cnt;
  assign out_valid = fsm == DONE;
  assign out_data  = out_valid ? st : '0;
  assign busy      = fsm != IDLE;
endmodule

// File: tb/tb_blink_round_iter.sv
// tb_blink_round_iter: randomized scoreboard bench for 64-bit/16-round and 128-bit/1-round engines
module tb_blink_round_iter;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;

  logic iv_a = 0, ir_a, rq_a, rv_a = 0, ov_a, or_a = 0, ab_a = 0, bz_a;
  logic [63:0] id_a = 0, rd_a = 0, od_a;
  logic [5:0] ix_a;
  logic iv_b = 0, ir_b, rq_b, rv_b = 0, ov_b, or_b = 0, ab_b = 0, bz_b;
  logic [127:0] id_b = 0, rd_b = 0, od_b;
  logic [0:0] ix_b;

  blink_round_iter #(.BLOCK_LEN(64), .NR(16), .IDXW(6)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
    .rk_req(rq_a), .rk_idx(ix_a), .rk_valid(rv_a), .rk_data(rd_a),
    .out_valid(ov_a), .out_ready(or_a), .out_data(od_a), .abort(ab_a), .busy(bz_a));
  blink_round_iter #(.BLOCK_LEN(128), .NR(1), .IDXW(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
    .rk_req(rq_b), .rk_idx(ix_b), .rk_valid(rv_b), .rk_data(rd_b),
    .out_valid(ov_b), .out_ready(or_b), .out_data(od_b), .abort(ab_b), .busy(bz_b));

  int nchk = 0, nfail = 0, cyc = 0;
  logic [127:0] ka [16];
  logic [127:0] kb [16];
  logic [127:0] qa[$], qb[$];
  int la[$], lb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [127:0] junk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // reference round built from the cipher definition: cells as integers, 4x4 binary matrix, permutation table
  function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k, input int bl);
    int sb [16] = '{12, 6, 9, 0, 1, 10, 2, 11, 3, 8, 5, 13, 4, 14, 7, 15};
    int pm [16] = '{0, 1, 2, 3, 7, 4, 5, 6, 10, 11, 8, 9, 13, 14, 15, 12};
    int mm [4][4] = '{'{1, 0, 1, 1}, '{1, 0, 0, 0}, '{0, 1, 1, 0}, '{1, 0, 1, 0}};
    int cw = bl / 16;
    int mask = (1 << cw) - 1;
    int c [16];
    int m [16];
    logic [127:0] y = '0;
    for (int i = 0; i < 16; i++) begin
      int v = int'(s[i*cw +: 8]) & mask;
      int r = 0;
      for (int j = 0; j < cw / 4; j++) r = r | (sb[(v >> (4 * j)) & 15] << (4 * j));
      c[i] = r ^ (int'(k[i*cw +: 8]) & mask);
    end
    for (int r = 0; r < 4; r++)
      for (int col = 0; col < 4; col++) begin
        m[r*4+col] = 0;
        for (int j = 0; j < 4; j++) if (mm[r][j] != 0) m[r*4+col] = m[r*4+col] ^ c[j*4+col];
      end
    for (int i = 0; i < 16; i++) y = y | (128'(m[pm[i]]) << (i * cw));
    return y;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] pt, input int bl, input int nr,
                                         input logic [127:0] ks [16]);
    logic [127:0] s = pt;
    for (int r = 0; r < nr; r++) s = ref_round(s, ks[r], bl);
    return s;
  endfunction

  int hs_a = 0, hs_b = 0;
  logic pv_a = 0, pv_b = 0;
  always @(negedge clk) begin
    if (iv_a && ir_a && !ab_a) hs_a = cyc;
    if (ov_a && !pv_a) begin
      if (qa.size() == 0) chk("a_unexpected_out", 1, 0);
      else begin
        chk("a_data", od_a, qa.pop_front());
        chk("a_latency", cyc - hs_a, la.pop_front());
      end
    end
    if (!ov_a) chk("a_zero_when_idle", od_a, 0);
    pv_a = ov_a;
  end
  always @(negedge clk) begin
    if (iv_b && ir_b && !ab_b) hs_b = cyc;
    if (ov_b && !pv_b) begin
      if (qb.size() == 0) chk("b_unexpected_out", 1, 0);
      else begin
        chk("b_data", od_b, qb.pop_front());
        chk("b_latency", cyc - hs_b, lb.pop_front());
      end
    end
    if (!ov_b) chk("b_zero_when_idle", od_b, 0);
    pv_b = ov_b;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input logic [63:0] pt, input int sat, input int slen, input int aat,
                       input int rat, input int hold);
    logic [127:0] exp = model(128'(pt), 64, 16, ka);
    bit early = 0;
    int n = 0;
    int left = slen;
    iv_a = 1;
    id_a = pt;
    if (aat < 0 && rat < 0) begin
      qa.push_back(exp);
      la.push_back(17 + slen);
    end
    step();
    iv_a = 0;
    id_a = junk();
    while (rq_a && n < 300) begin
      rv_a = 1;
      if (ix_a == sat && left > 0) begin
        rv_a = 0;
        left--;
        chk("a_stall_idx", ix_a, sat);
      end
      rd_a = rv_a ? ka[ix_a][63:0] : junk();
      if (ix_a == aat) begin
        ab_a = 1;
        early = 1;
      end
      if (ix_a == rat) begin
        #2 rst_n = 0;
        #1 chk("a_async_reset", {ir_a, rq_a, ov_a, bz_a, 2'b0, ix_a, od_a}, {4'b1000, 72'h0});
        step();
        step();
        rst_n = 1;
        early = 1;
      end
      step();
      ab_a = 0;
      n++;
      if (early) begin
        chk("a_cancel_idle", {ir_a, ov_a, bz_a}, 3'b100);
        break;
      end
    end
    rv_a = 1'($urandom);
    rd_a = junk();
    if (n >= 300) chk("a_timeout", 1, 0);
    if (!early) begin
      chk("a_done", ov_a, 1);
      for (int h = 0; h < hold; h++) begin
        chk("a_hold_data", od_a, exp);
        chk("a_hold_in_ready", ir_a, 0);
        step();
      end
      or_a = 1;
      iv_a = 1;
      step();
      or_a = 0;
      iv_a = 0;
      chk("a_back_idle", {ir_a, ov_a, bz_a}, 3'b100);
    end
  endtask

  task automatic run_b(input logic [127:0] pt, input int slen);
    iv_b = 1;
    id_b = pt;
    qb.push_back(model(pt, 128, 1, kb));
    lb.push_back(2 + slen);
    step();
    iv_b = 0;
    for (int i = 0; i < slen; i++) begin
      rv_b = 0;
      rd_b = junk();
      chk("b_stall_idx", {rq_b, ix_b}, 2'b10);
      step();
    end
    rv_b = 1;
    rd_b = kb[0];
    step();
    rv_b = 0;
    chk("b_done", {ov_b, ir_b}, 2'b10);
    or_b = 1;
    step();
    or_b = 0;
    chk("b_back_idle", {ir_b, bz_b}, 2'b10);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ka[i] = junk();
      kb[i] = junk();
    end
    step();
    chk("reset_a", {ir_a, rq_a, ov_a, bz_a, 2'b0, ix_a, od_a}, {4'b1000, 72'h0});
    chk("reset_b", {ir_b, rq_b, ov_b, bz_b, ix_b, od_b}, {4'b1000, 129'h0});
    step();
    rst_n = 1;
    step();
    run_a(junk(), -1, 0, -1, -1, 0);
    run_a(junk(), 5, 3, -1, -1, 0);
    run_a(junk(), -1, 0, -1, -1, 10);
    run_a(junk(), -1, 0, 7, -1, 0);
    run_a(junk(), -1, 0, -1, -1, 0);
    iv_a = 1;
    ab_a = 1;
    id_a = junk();
    step();
    iv_a = 0;
    ab_a = 0;
    chk("a_abort_in_idle", {ir_a, bz_a}, 2'b10);
    run_a(junk(), -1, 0, -1, 3, 0);
    repeat (5) step();
    run_a(junk(), -1, 0, -1, -1, 0);
    for (int t = 0; t < 20; t++)
      run_a(junk(), $urandom_range(0, 15), $urandom_range(0, 3), -1, -1, $urandom_range(0, 3));
    run_b(junk(), 0);
    run_b(junk(), 2);
    for (int t = 0; t < 6; t++) run_b(junk(), $urandom_range(0, 3));
    repeat (5) step();
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
